// File: rtl/pif_reg_sequencer.sv
// Tagged-byte command sequencer between the I2C slave byte interface and the register bank.
// Optional feature: define PIF_REG_ERRCNT_EN for a local saturating error counter at pointer 6'h3F.
module pif_reg_sequencer #(
  parameter int DATA_BITS  = 6,
  parameter int NUM_REGS   = 8,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  input  logic                 i2c_stop,
  output logic [DATA_BITS-1:0] reg_addr,
  output logic                 reg_wr_en,
  output logic [DATA_BITS-1:0] reg_wdata,
  output logic                 reg_rd_en,
  input  logic [DATA_BITS-1:0] reg_rdata,
  input  logic                 reg_rd_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 err_pulse
);

  localparam logic [1:0] TAG_A = 2'b00;
  localparam logic [1:0] TAG_D = 2'b01;
  localparam logic [1:0] TAG_R = 2'b10;

  localparam int TW = $clog2(RD_TIMEOUT) + 1;
  localparam logic [TW-1:0]          T_LAST = TW'(RD_TIMEOUT - 1);
  localparam logic [DATA_BITS-1:0]   P_LAST = DATA_BITS'(NUM_REGS - 1);
  localparam logic [DATA_BITS:0]     N_REGS = (DATA_BITS + 1)'(NUM_REGS);
  localparam logic [DATA_BITS-1:0]   LOCAL_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_TX
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [DATA_BITS-1:0]   r_ptr, w_ptr_nxt;
  logic [DATA_BITS-1:0]   r_wdata, w_wdata_nxt;
  logic [7:0]             r_tx_data, w_tx_data_nxt;
  logic                   r_tx_valid, w_tx_valid_nxt;
  logic [TW-1:0]          r_tcnt, w_tcnt_nxt;
  logic                   r_err, w_err;
  logic [1:0]             w_tag;
  logic [DATA_BITS-1:0]   w_pay;

`ifdef PIF_REG_ERRCNT_EN
  logic [7:0]             r_errcnt;
  logic                   w_cnt_clr;
`endif

  function automatic logic [DATA_BITS-1:0] ptr_inc(input logic [DATA_BITS-1:0] p);
    if (p >= P_LAST) return '0;
    return p + DATA_BITS'(1);
  endfunction

  function automatic logic addr_ok(input logic [DATA_BITS-1:0] a);
`ifdef PIF_REG_ERRCNT_EN
    if (a == LOCAL_ADDR) return 1'b1;
`endif
    return ({1'b0, a} < N_REGS);
  endfunction

  assign w_tag = rx_data[7:6];
  assign w_pay = rx_data[DATA_BITS-1:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_wdata_nxt    = r_wdata;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_tcnt_nxt     = r_tcnt;
    w_err          = 1'b0;
`ifdef PIF_REG_ERRCNT_EN
    w_cnt_clr      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          case (w_tag)
            TAG_A: begin
              if (addr_ok(w_pay)) w_ptr_nxt = w_pay;
              else                w_err     = 1'b1;
            end
            TAG_D: begin
              w_wdata_nxt = w_pay;
              w_state_nxt = S_WRITE;
            end
            TAG_R: begin
`ifdef PIF_REG_ERRCNT_EN
              if (r_ptr == LOCAL_ADDR) begin
                w_tx_data_nxt  = r_errcnt;
                w_tx_valid_nxt = 1'b1;
                w_cnt_clr      = 1'b1;
                w_state_nxt    = S_TX;
              end else begin
                w_state_nxt = S_RD_ISSUE;
              end
`else
              w_state_nxt = S_RD_ISSUE;
`endif
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      // A write always completes, even across an I2C STOP
      S_WRITE: begin
        w_err       = rx_valid;
        w_ptr_nxt   = ptr_inc(r_ptr);
        w_state_nxt = S_IDLE;
      end
      S_RD_ISSUE: begin
        w_err = rx_valid;
        if (i2c_stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_tcnt_nxt  = '0;
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        w_err = rx_valid;
        if (i2c_stop) begin
          w_state_nxt = S_IDLE;
        end else if (reg_rd_ack) begin
          w_tx_data_nxt  = {2'b01, reg_rdata};
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = S_TX;
        end else if (r_tcnt == T_LAST) begin
          w_tx_data_nxt  = 8'hFF;
          w_tx_valid_nxt = 1'b1;
          w_err          = 1'b1;
          w_state_nxt    = S_TX;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      // STOP wins over a coincident handshake: the read is abandoned
      S_TX: begin
        w_err = rx_valid;
        if (i2c_stop) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end else if (tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          w_ptr_nxt      = ptr_inc(r_ptr);
          w_state_nxt    = S_IDLE;
        end
      end
      default: begin
        w_tx_valid_nxt = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_wdata    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tcnt     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_err      <= w_err;
    end
  end

`ifdef PIF_REG_ERRCNT_EN
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_errcnt <= '0;
    end else if (w_cnt_clr) begin
      r_errcnt <= '0;
    end else if (w_err && (r_errcnt != 8'hFF)) begin
      r_errcnt <= r_errcnt + 8'd1;
    end
  end
`endif

  assign rx_ready  = (r_state == S_IDLE);
  assign reg_wr_en = (r_state == S_WRITE);
  assign reg_rd_en = (r_state == S_RD_ISSUE);
  assign reg_addr  = r_ptr;
  assign reg_wdata = r_wdata;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign err_pulse = r_err;

endmodule
